// File: rtl/lcd1602_bus_arbiter.sv
// Round-robin arbiter for the shared LCD1602 write bus: grants one {rs,data}
// write at a time and produces the setup / enable / hold / execution timing.
module lcd1602_bus_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int DATA_BITS        = 8,
  parameter int SETUP_CYCLES     = 4,
  parameter int EN_CYCLES        = 25,
  parameter int HOLD_CYCLES      = 4,
  parameter int EXEC_CYCLES      = 2500,
  parameter int LONG_EXEC_CYCLES = 82000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_rs,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic                           lcd_rs,
  output logic                           lcd_rw,
  output logic                           lcd_en,
  output logic [DATA_BITS-1:0]           lcd_data
);

  localparam int MAX_A   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
  localparam int MAX_C   = (MAX_B > LONG_EXEC_CYCLES) ? MAX_B : LONG_EXEC_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 lcd_rs_q, lcd_rs_d;
  logic                 lcd_en_q, lcd_en_d;
  logic [DATA_BITS-1:0] lcd_data_q, lcd_data_d;

  logic [PTR_W-1:0]     gnt;
  logic                 gnt_vld;
  logic                 is_long;
  logic [CNT_W-1:0]     exec_last;

  // Walk the ring from the farthest candidate to the nearest so that the
  // requester closest after last_q is the one left in gnt.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last_q) + i) % NUM_REQ]) begin
        gnt     = PTR_W'((int'(last_q) + i) % NUM_REQ);
        gnt_vld = 1'b1;
      end
    end
  end

  // Clear display and return-home need the long execution wait.
  assign is_long   = !lcd_rs_q && (lcd_data_q[DATA_BITS-1:2] == '0) && (lcd_data_q[1:0] != 2'b00);
  assign exec_last = is_long ? LONG_LAST : EXEC_LAST;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    last_d     = last_q;
    ack_d      = '0;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_vld) begin
          state_d    = SETUP;
          last_d     = gnt;
          ack_d[gnt] = 1'b1;
          lcd_rs_d   = req_rs[gnt];
          lcd_data_d = req_data[int'(gnt)*DATA_BITS +: DATA_BITS];
        end
      end
      SETUP: if (cnt_q == SETUP_LAST) begin state_d = PULSE; cnt_d = '0; end
      PULSE: if (cnt_q == EN_LAST)    begin state_d = HOLD;  cnt_d = '0; end
      HOLD:  if (cnt_q == HOLD_LAST)  begin state_d = EXEC;  cnt_d = '0; end
      EXEC:  if (cnt_q == exec_last)  begin state_d = IDLE;  cnt_d = '0; end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    lcd_en_d = (state_d == PULSE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= PTR_W'(NUM_REQ - 1);
      ack_q      <= '0;
      busy_q     <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd1602_bus_arbiter.sv
// Bench for lcd1602_bus_arbiter: single-write timing table, hand-written
// arbitration/reset sequences and a randomized run against a reference model.
module tb_lcd1602_bus_arbiter;
  localparam int NR = 2;
  localparam int DB = 8;
  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int X  = 5;
  localparam int XL = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req, req_rs;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             busy, lcd_rs, lcd_rw, lcd_en;
  logic [DB-1:0]    lcd_data;

  lcd1602_bus_arbiter #(
    .NUM_REQ(NR), .DATA_BITS(DB), .SETUP_CYCLES(S), .EN_CYCLES(E),
    .HOLD_CYCLES(H), .EXEC_CYCLES(X), .LONG_EXEC_CYCLES(XL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rs(req_rs), .req_data(req_data),
    .ack(ack), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a write is described by its offset k since the ack
  // cycle (k=1) and its total busy length; the cycle after that is idle.
  bit            m_active;
  int            m_k, m_total, m_last;
  logic [NR-1:0] m_ack;
  logic          m_rs;
  logic [DB-1:0] m_data;

  function automatic int exec_len(logic rs, logic [DB-1:0] d);
    return (!rs && d >= 1 && d <= 3) ? XL : X;
  endfunction

  task automatic check_val(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    int g;
    m_ack = '0;
    if (reset) begin
      m_active = 0; m_k = 0; m_last = NR - 1; m_rs = 1'b0; m_data = '0;
    end else if (!m_active) begin
      for (int i = 1; i <= NR; i++) begin
        g = (m_last + i) % NR;
        if (req[g]) begin
          m_active = 1; m_k = 1; m_last = g; m_ack[g] = 1'b1;
          m_rs     = req_rs[g];
          m_data   = req_data[g*DB +: DB];
          m_total  = S + E + H + exec_len(m_rs, m_data);
          break;
        end
      end
    end else begin
      m_k++;
      if (m_k > m_total) m_active = 0;
    end
  endtask

  task automatic step();
    logic en_e;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    en_e = m_active && (m_k > S) && (m_k <= S + E);
    check_val("outputs{ack,busy,rs,rw,en,data}",
              int'({ack, busy, lcd_rs, lcd_rw, lcd_en, lcd_data}),
              int'({m_ack, m_active, m_rs, 1'b0, en_e, m_data}));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    step();
    check_val("reset_outputs", int'({ack, busy, lcd_rs, lcd_rw, lcd_en, lcd_data}), 0);
    reset = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         en_first;
    int         en_last;
    int         idle_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ack_cyc, en_first, en_last, idle_cyc, first_ack;
    logic [7:0] d1;
    logic r1;
    int exp_c[4];
    int exp_g[4];
    int k;

    vecs[0] = '{1'b1, 8'h41, 3, 5, 13};
    vecs[1] = '{1'b0, 8'h01, 3, 5, 20};
    vecs[2] = '{1'b0, 8'h02, 3, 5, 20};
    vecs[3] = '{1'b0, 8'h03, 3, 5, 20};
    vecs[4] = '{1'b1, 8'h01, 3, 5, 13};
    vecs[5] = '{1'b0, 8'h00, 3, 5, 13};
    vecs[6] = '{1'b0, 8'h04, 3, 5, 13};
    vecs[7] = '{1'b0, 8'h81, 3, 5, 13};
    vecs[8] = '{1'b1, 8'h02, 3, 5, 13};

    reset = 1'b1; req = '0; req_rs = '0; req_data = '0;
    m_active = 0; m_k = 0; m_total = 0; m_last = NR - 1; m_ack = '0; m_rs = 0; m_data = '0;

    // Single writes from requester 0: timing and long-exec decode.
    foreach (vecs[v]) begin
      do_reset();
      req[0] = 1'b1; req_rs[0] = vecs[v].rs; req_data[7:0] = vecs[v].data;
      ack_cyc = -1; en_first = -1; en_last = -1; idle_cyc = -1; d1 = '0; r1 = 1'b0;
      for (int c = 1; c <= 40 && idle_cyc < 0; c++) begin
        step();
        if (ack[0]) begin
          if (ack_cyc < 0) ack_cyc = c;
          req[0] = 1'b0;
        end
        if (lcd_en) begin
          if (en_first < 0) en_first = c;
          en_last = c;
        end
        if (!busy && idle_cyc < 0) idle_cyc = c;
        if (c == 1) begin d1 = lcd_data; r1 = lcd_rs; end
      end
      check_val("vec_ack_cycle", ack_cyc, 1);
      check_val("vec_en_first", en_first, vecs[v].en_first);
      check_val("vec_en_last", en_last, vecs[v].en_last);
      check_val("vec_idle_cycle", idle_cyc, vecs[v].idle_cyc);
      check_val("vec_latched_data", int'(d1), int'(vecs[v].data));
      check_val("vec_latched_rs", int'(r1), int'(vecs[v].rs));
    end

    // Both requesters held high: grants alternate every 13 cycles.
    do_reset();
    req = 2'b11; req_rs = 2'b11; req_data = {8'h31, 8'h30};
    exp_c = '{1, 14, 27, 40};
    exp_g = '{0, 1, 0, 1};
    k = 0;
    for (int c = 1; c <= 45; c++) begin
      step();
      if (ack != '0) begin
        if (k < 4) begin
          check_val("rr_ack_cycle", cyc, exp_c[k]);
          check_val("rr_ack_vec", int'(ack), 1 << exp_g[k]);
          check_val("rr_data", int'(lcd_data), 8'h30 + exp_g[k]);
        end
        k++;
      end
    end
    check_val("rr_ack_count", k, 4);
    req = '0;

    // Reset during PULSE aborts; requester 0 then wins the tie.
    do_reset();
    req[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h41;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (ack[0]) req[0] = 1'b0;
    end
    check_val("pulse_before_reset", int'(lcd_en), 1);
    reset = 1'b1;
    step();
    check_val("abort_en", int'(lcd_en), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_all", int'({ack, busy, lcd_rs, lcd_rw, lcd_en, lcd_data}), 0);
    reset = 1'b0;
    req = 2'b11; req_rs = 2'b10; req_data = {8'h55, 8'h66};
    step();
    check_val("tie_after_reset", int'(ack), 1);
    check_val("tie_data", int'(lcd_data), 8'h66);
    req[0] = 1'b0;
    for (int c = 0; c < 30 && req[1]; c++) begin
      step();
      if (ack[1]) req[1] = 1'b0;
    end
    check_val("tie_second_grant_done", int'(req[1]), 0);

    // Only requester 1 first; requester 0 arrives during EXEC.
    do_reset();
    req = 2'b10; req_rs = 2'b00; req_data = {8'h38, 8'h0C};
    step();
    check_val("solo1_ack", int'(ack), 2);
    req[1] = 1'b0;
    first_ack = -1;
    for (int c = 2; c <= 30 && first_ack < 0; c++) begin
      step();
      if (cyc == 10) req[0] = 1'b1;
      if (ack != '0) begin
        first_ack = cyc;
        check_val("late0_ack_vec", int'(ack), 1);
        req[0] = 1'b0;
      end
    end
    check_val("late0_ack_cycle", first_ack, 14);

    // Held req with data changed after the latch edge.
    do_reset();
    req[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h41;
    first_ack = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 2) req_data[7:0] = 8'h42;
      if (c == 5) check_val("hold_first_byte", int'(lcd_data), 8'h41);
      if (c > 1 && ack[0] && first_ack < 0) begin
        first_ack = c;
        req[0] = 1'b0;
      end
      if (c == 15) check_val("second_byte", int'(lcd_data), 8'h42);
    end
    check_val("second_ack_cycle", first_ack, 14);

    // Randomized traffic with occasional resets, checked every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom % 400) == 0;
      step();
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          if ($urandom % 4 != 0) req[i] = 1'b0;
          else req_data[i*DB +: DB] = 8'($urandom);
        end else if (!req[i] && ($urandom % 6) == 0) begin
          req[i]    = 1'b1;
          req_rs[i] = 1'($urandom);
          req_data[i*DB +: DB] = ($urandom % 3 == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
